// File: rtl/apb_mem_completer_if.sv
// APB request/response bundle between a requester (master) and the memory completer (slave).
interface apb_mem_completer_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                      psel;
   logic                      penable;
   logic                      pwrite;
   logic [ADDR_WIDTH-1:0]     paddr;
   logic [DATA_WIDTH-1:0]     pwdata;
   logic [DATA_WIDTH/8-1:0]   pstrb;
   logic [DATA_WIDTH-1:0]     prdata;
   logic                      pready;
   logic                      pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_mem_completer.sv
// APB completer backed by a register-file memory with byte strobes, fixed wait states
// and an error response for addresses outside the mapped window.
module apb_mem_completer #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_0000),
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           MEM_SIZE   = 32,
   parameter int unsigned           WAIT_CYCLE = 3
) (
   input  logic               clk,
   input  logic               rst,
   apb_mem_completer_if.slave bus
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned AW1    = ADDR_WIDTH + 1;
   localparam int unsigned IDX_W  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam int unsigned CNT_W  = (WAIT_CYCLE > 0) ? $clog2(WAIT_CYCLE + 1) : 1;

   // Window bounds carry one extra bit so BASE_ADDR+MEM_SIZE never wraps onto low addresses.
   localparam logic [AW1-1:0]   BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [AW1-1:0]   LIMIT_EXT = BASE_EXT + AW1'(MEM_SIZE);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WAIT_CYCLE);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t                  state_q,   state_d;
   logic [CNT_W-1:0]        cnt_q,     cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
   logic                    wr_q,      wr_d;
   logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
   logic [STRB_W-1:0]       strb_q,    strb_d;
   logic                    pready_q,  pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;
   logic [DATA_WIDTH-1:0]   mem_q [MEM_SIZE];
   logic [DATA_WIDTH-1:0]   mem_d [MEM_SIZE];

   logic [ADDR_WIDTH-1:0]   xfer_addr_s;
   logic                    xfer_wr_s;
   logic [AW1-1:0]          addr_ext_s;
   logic                    in_range_s;
   logic [IDX_W-1:0]        idx_s;
   logic                    raise_s;

   // Transfer attributes: live bus values on the setup edge, captured copies afterwards.
   always_comb begin
      if (state_q == IDLE) begin
         xfer_addr_s = bus.paddr;
         xfer_wr_s   = bus.pwrite;
      end else begin
         xfer_addr_s = addr_q;
         xfer_wr_s   = wr_q;
      end
      addr_ext_s = {1'b0, xfer_addr_s};
      in_range_s = (addr_ext_s >= BASE_EXT) && (addr_ext_s < LIMIT_EXT);
      idx_s      = IDX_W'(addr_ext_s - BASE_EXT);
   end

   // Next-state, wait counting, response generation and memory update.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      prdata_d  = prdata_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      mem_d     = mem_q;
      raise_s   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.psel && !bus.penable) begin
               state_d = ACCESS;
               addr_d  = bus.paddr;
               wr_d    = bus.pwrite;
               wdata_d = bus.pwdata;
               strb_d  = bus.pstrb;
               cnt_d   = CNT_LOAD;
               raise_s = (WAIT_CYCLE == 32'd0);
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (!bus.psel) begin
               state_d = IDLE;
            end else if (pready_q) begin
               // The completing edge is the only place memory is written.
               state_d = IDLE;
               if (wr_q && in_range_s) begin
                  for (int i = 0; i < int'(STRB_W); i++) begin
                     if (strb_q[i]) begin
                        mem_d[idx_s][8*i +: 8] = wdata_q[8*i +: 8];
                     end else begin
                        mem_d[idx_s][8*i +: 8] = mem_q[idx_s][8*i +: 8];
                     end
                  end
               end else begin
                  mem_d = mem_q;
               end
            end else begin
               raise_s = (cnt_q == CNT_ONE);
               if (cnt_q != CNT_ZERO) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else begin
                  cnt_d = cnt_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (raise_s) begin
         pready_d = 1'b1;
         if (!in_range_s) begin
            pslverr_d = 1'b1;
         end else if (!xfer_wr_s) begin
            prdata_d = mem_q[idx_s];
         end else begin
            prdata_d = prdata_q;
         end
      end else begin
         pready_d = 1'b0;
      end
   end

   // State, captured request, registered response and memory array.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= CNT_ZERO;
         addr_q    <= {ADDR_WIDTH{1'b0}};
         wr_q      <= 1'b0;
         wdata_q   <= {DATA_WIDTH{1'b0}};
         strb_q    <= {STRB_W{1'b0}};
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= {DATA_WIDTH{1'b0}};
         for (int i = 0; i < int'(MEM_SIZE); i++) begin
            mem_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         mem_q     <= mem_d;
      end
   end

   assign bus.prdata  = prdata_q;
   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Randomized and directed bench for apb_mem_completer; two instances (3 and 0 wait states)
// are checked every cycle against a transaction-level model of the memory and its timing.
module tb_apb_mem_completer;

   localparam int WAIT_MAX = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   apb_mem_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();
   apb_mem_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();

   apb_mem_completer #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0000_0000), .DATA_WIDTH(32),
                       .MEM_SIZE(32), .WAIT_CYCLE(3)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (b3)
   );

   apb_mem_completer #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0000_0000), .DATA_WIDTH(32),
                       .MEM_SIZE(32), .WAIT_CYCLE(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   typedef struct packed {
      logic        sel;
      logic        en;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } apb_in_t;

   typedef struct packed {
      logic [31:0] rd;
      logic        rdy;
      logic        err;
   } apb_out_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_on   = 1'b0;

   function automatic apb_in_t make_in(input logic sel, input logic en, input logic wr,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] strb);
      apb_in_t v;
      v.sel = sel; v.en = en; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
      return v;
   endfunction

   function automatic apb_in_t get_in(input int d);
      apb_in_t v;
      if (d == 0) v = make_in(b3.psel, b3.penable, b3.pwrite, b3.paddr, b3.pwdata, b3.pstrb);
      else        v = make_in(b0.psel, b0.penable, b0.pwrite, b0.paddr, b0.pwdata, b0.pstrb);
      return v;
   endfunction

   function automatic apb_out_t get_out(input int d);
      apb_out_t o;
      if (d == 0) begin o.rd = b3.prdata; o.rdy = b3.pready; o.err = b3.pslverr; end
      else        begin o.rd = b0.prdata; o.rdy = b0.pready; o.err = b0.pslverr; end
      return o;
   endfunction

   task automatic set_bus(input int d, input apb_in_t v);
      if (d == 0) begin
         b3.psel = v.sel; b3.penable = v.en; b3.pwrite = v.wr;
         b3.paddr = v.addr; b3.pwdata = v.wdata; b3.pstrb = v.strb;
      end else begin
         b0.psel = v.sel; b0.penable = v.en; b0.pwrite = v.wr;
         b0.paddr = v.addr; b0.pwdata = v.wdata; b0.pstrb = v.strb;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Memory window is [0, 32); a transfer is "busy" from its setup until the end of access
   // cycle WAIT+1, which is the one cycle where ready (and error/read data) must show.
   logic [31:0] m_mem [2][32];
   bit          m_busy [2];
   int          m_acc  [2];
   apb_in_t     m_cap  [2];
   logic [31:0] e_rd   [2];
   logic        e_rdy  [2];
   logic        e_err  [2];

   function automatic bit in_win(input logic [31:0] a);
      longint unsigned x;
      x = {32'h0, a};
      return (x < 64'd32);
   endfunction

   always @(posedge clk) begin
      apb_in_t mi;
      int      w;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         mi = get_in(d);
         w  = (d == 0) ? 3 : 0;
         if (rst) begin
            m_busy[d] = 1'b0; m_acc[d] = 0;
            e_rdy[d] = 1'b0; e_err[d] = 1'b0; e_rd[d] = 32'h0;
            for (int k = 0; k < 32; k++) m_mem[d][k] = 32'h0;
         end else begin
            e_rdy[d] = 1'b0;
            e_err[d] = 1'b0;
            if (!m_busy[d]) begin
               if (mi.sel && !mi.en) begin
                  m_busy[d] = 1'b1; m_acc[d] = 1; m_cap[d] = mi;
               end
            end else if (m_acc[d] == w + 1) begin
               if (mi.sel && m_cap[d].wr && in_win(m_cap[d].addr))
                  for (int l = 0; l < 4; l++)
                     if (m_cap[d].strb[l])
                        m_mem[d][int'(m_cap[d].addr)][8*l +: 8] = m_cap[d].wdata[8*l +: 8];
               m_busy[d] = 1'b0;
            end else if (!mi.sel) begin
               m_busy[d] = 1'b0;
            end else begin
               m_acc[d]++;
            end
            if (m_busy[d] && m_acc[d] == w + 1) begin
               e_rdy[d] = 1'b1;
               if (!in_win(m_cap[d].addr)) e_err[d] = 1'b1;
               else if (!m_cap[d].wr) e_rd[d] = m_mem[d][int'(m_cap[d].addr)];
            end
         end
      end
   end

   // Every cycle: both instances against the model, sampled mid-cycle.
   always @(negedge clk) begin
      apb_out_t o;
      if (chk_on) begin
         for (int d = 0; d < 2; d++) begin
            o = get_out(d);
            chk($sformatf("pready[%0d]@%0d", d, cyc),  {31'h0, o.rdy}, {31'h0, e_rdy[d]});
            chk($sformatf("pslverr[%0d]@%0d", d, cyc), {31'h0, o.err}, {31'h0, e_err[d]});
            chk($sformatf("prdata[%0d]@%0d", d, cyc),  o.rd, e_rd[d]);
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called and returning on a falling edge; abort_at>0 drops psel in that access cycle.
   task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input int abort_at, output logic [31:0] rd,
                       output logic err, output int acc, output int at);
      apb_out_t o;
      bit       done;
      rd = 32'h0; err = 1'b0; acc = 0; at = 0; done = 1'b0;
      set_bus(d, make_in(1'b1, 1'b0, wr, a, wd, s));
      for (int k = 1; k <= WAIT_MAX && !done; k++) begin
         @(negedge clk);
         if (k == abort_at) begin
            set_bus(d, make_in(1'b0, 1'b0, wr, a, wd, s));
            done = 1'b1;
         end else begin
            set_bus(d, make_in(1'b1, 1'b1, wr, a, wd, s));
            o = get_out(d);
            if (o.rdy) begin
               rd = o.rd; err = o.err; acc = k; at = cyc; done = 1'b1;
            end
         end
      end
      if (abort_at == 0) begin
         n_checks++;
         if (!done) begin
            n_fail++;
            $display("FAIL xfer_timeout: dut %0d addr %h got no pready in %0d cycles, expected one",
                     d, a, WAIT_MAX);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int d, input int n, input bit noisy);
      int r;
      for (int i = 0; i < n; i++) begin
         r = noisy ? $urandom_range(0, 2) : 0;
         set_bus(d, make_in(r == 2, r != 0, $urandom_range(0, 1), $urandom, $urandom,
                            4'($urandom_range(0, 15))));
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        err;
      int          acc, at, at0;
      apb_out_t    o;

      set_bus(0, make_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0));
      set_bus(1, make_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0));
      @(negedge clk);
      chk_on = 1'b1;
      @(negedge clk);
      o = get_out(0);
      chk("rst_prdata", o.rd, 32'h0);
      chk("rst_pready", {31'h0, o.rdy}, 32'h0);
      chk("rst_pslverr", {31'h0, o.err}, 32'h0);
      rst = 1'b0;

      // Single write/read with three wait states.
      xfer(0, 1'b1, 32'd5, 32'hDEAD_0005, 4'hF, 0, rd, err, acc, at);
      chk("w5_access_cycles", acc, 32'd4);
      chk("w5_pslverr", {31'h0, err}, 32'h0);
      xfer(0, 1'b0, 32'd5, 32'h0, 4'h0, 0, rd, err, acc, at);
      chk("r5_data", rd, 32'hDEAD_0005);

      // Abort in access cycle 2: no ready ever, no write.
      xfer(0, 1'b1, 32'd7, 32'hCAFE_F00D, 4'hF, 2, rd, err, acc, at);
      for (int i = 0; i < 6; i++) begin
         o = get_out(0);
         chk("abort_no_pready", {31'h0, o.rdy}, 32'h0);
         @(negedge clk);
      end
      xfer(0, 1'b0, 32'd7, 32'h0, 4'h0, 0, rd, err, acc, at);
      chk("r7_after_abort", rd, 32'h0);

      // Partial strobes and an all-zero strobe.
      xfer(0, 1'b1, 32'd2, 32'h1122_3344, 4'hF, 0, rd, err, acc, at);
      xfer(0, 1'b1, 32'd2, 32'hAABB_CCDD, 4'b0101, 0, rd, err, acc, at);
      xfer(0, 1'b0, 32'd2, 32'h0, 4'h0, 0, rd, err, acc, at);
      chk("r2_strobed", rd, 32'h11BB_33DD);
      xfer(0, 1'b1, 32'd2, 32'hFFFF_FFFF, 4'h0, 0, rd, err, acc, at);
      chk("w2_nostrb_err", {31'h0, err}, 32'h0);
      xfer(0, 1'b0, 32'd2, 32'h0, 4'h0, 0, rd, err, acc, at);
      chk("r2_nostrb", rd, 32'h11BB_33DD);

      // Fill the whole window, read it back plus one past the end.
      for (int i = 0; i < 32; i++)
         xfer(0, 1'b1, i, 32'hDEAD_0000 + i, 4'hF, 0, rd, err, acc, at);
      for (int i = 0; i < 33; i++) begin
         xfer(0, 1'b0, i, 32'h0, 4'h0, 0, rd, err, acc, at);
         if (i < 32) begin
            chk($sformatf("fill_rd%0d", i), rd, 32'hDEAD_0000 + i);
            chk($sformatf("fill_err%0d", i), {31'h0, err}, 32'h0);
         end else begin
            chk("oor_err", {31'h0, err}, 32'h1);
            chk("oor_prdata_held", rd, 32'hDEAD_001F);
         end
      end

      // Zero wait states, back-to-back writes.
      xfer(1, 1'b1, 32'd0, 32'h0000_A0A0, 4'hF, 0, rd, err, acc, at0);
      chk("b2b_acc0", acc, 32'd1);
      xfer(1, 1'b1, 32'd1, 32'h0000_A1A1, 4'hF, 0, rd, err, acc, at);
      chk("b2b_acc1", acc, 32'd1);
      chk("b2b_spacing", at - at0, 32'd2);
      xfer(1, 1'b0, 32'd0, 32'h0, 4'h0, 0, rd, err, acc, at);
      chk("b2b_r0", rd, 32'h0000_A0A0);
      xfer(1, 1'b0, 32'd1, 32'h0, 4'h0, 0, rd, err, acc, at);
      chk("b2b_r1", rd, 32'h0000_A1A1);

      // Reset during a wait state of a write.
      set_bus(0, make_in(1'b1, 1'b0, 1'b1, 32'd9, 32'h5555_AAAA, 4'hF));
      @(negedge clk);
      set_bus(0, make_in(1'b1, 1'b1, 1'b1, 32'd9, 32'h5555_AAAA, 4'hF));
      @(negedge clk);
      rst = 1'b1;
      set_bus(0, make_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0));
      @(negedge clk);
      o = get_out(0);
      chk("rst_mid_pready", {31'h0, o.rdy}, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         xfer(0, 1'b0, i, 32'h0, 4'h0, 0, rd, err, acc, at);
         chk($sformatf("rst_clr%0d", i), rd, 32'h0);
      end
      xfer(1, 1'b0, 32'd0, 32'h0, 4'h0, 0, rd, err, acc, at);
      chk("rst_clr_dut0", rd, 32'h0);
      xfer(0, 1'b1, 32'd9, 32'h1234_5678, 4'hF, 0, rd, err, acc, at);
      chk("post_rst_acc", acc, 32'd4);
      xfer(0, 1'b0, 32'd9, 32'h0, 4'h0, 0, rd, err, acc, at);
      chk("post_rst_rd", rd, 32'h1234_5678);

      // Random traffic; the per-cycle model compare does the checking.
      for (int it = 0; it < 300; it++) begin
         int          d, ab, r;
         logic        wr;
         logic [31:0] a;
         d  = $urandom_range(0, 1);
         wr = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 39);
         a  = (r < 36) ? 32'(r) : $urandom;
         ab = (d == 0 && $urandom_range(0, 6) == 0) ? $urandom_range(1, 3) : 0;
         xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), ab, rd, err, acc, at);
         idle(d, $urandom_range(0, 2), 1'b1);
      end

      idle(0, 2, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_mem_completer.md
APB_MEM_COMPLETER -- requirements
Module: apb_mem_completer

Interface
REQ-001 SHALL take parameter BASE_ADDR, default 32'h0000_0000, the word address of memory location 0.
REQ-002 SHALL take parameter ADDR_WIDTH, default 32, the PADDR width.
REQ-003 SHALL take parameter DATA_WIDTH, default 32, the PWDATA/PRDATA width (a multiple of 8).
REQ-004 SHALL take parameter MEM_SIZE, default 32, the number of DATA_WIDTH-bit words.
REQ-005 SHALL take parameter WAIT_CYCLE, default 3, the number of wait states inserted per transfer (0 allowed).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port psel, input, 1, the APB select.
REQ-009 SHALL have port penable, input, 1, the APB access-phase enable.
REQ-010 SHALL have port pwrite, input, 1, which selects write when 1 and read when 0.
REQ-011 SHALL have port paddr, input, ADDR_WIDTH, the word address.
REQ-012 SHALL have port pwdata, input, DATA_WIDTH, the write data.
REQ-013 SHALL have port pstrb, input, DATA_WIDTH/8, the write byte enables.
REQ-014 SHALL have port prdata, output, DATA_WIDTH, the read data.
REQ-015 SHALL have port pready, output, 1, the transfer-complete indication.
REQ-016 SHALL have port pslverr, output, 1, the error response, valid only while pready=1.

Function
REQ-017 SHALL implement the states IDLE and ACCESS.
- IDLE -> ACCESS on a setup cycle (psel=1, penable=0).
- ACCESS -> IDLE on the cycle after pready=1, or on psel=0.
REQ-018 SHALL capture paddr, pwrite, pwdata and pstrb on the setup-cycle edge and use only the captured values for the rest of the transfer.
REQ-019 SHALL drive pready=0 for the first WAIT_CYCLE access cycles and pready=1 on access cycle WAIT_CYCLE+1.
- Total transfer length is WAIT_CYCLE+2 cycles, setup included.
- With WAIT_CYCLE=0, pready SHALL be 1 in the first access cycle.
REQ-020 SHALL hold pready=1 for exactly one cycle per transfer; pready SHALL be 0 in IDLE.
REQ-021 SHALL use the wait counter width $clog2(WAIT_CYCLE+1), minimum 1 bit, reload it at every setup, and never let it wrap.
REQ-022 SHALL compute the word index as captured paddr minus BASE_ADDR.
- The access is in range when BASE_ADDR <= paddr < BASE_ADDR+MEM_SIZE.
- Range arithmetic SHALL be done at ADDR_WIDTH+1 bits so that no wrap-around aliasing occurs near 2^ADDR_WIDTH.
REQ-023 For an in-range write, SHALL update each byte lane i with pstrb[i]=1 from the captured pwdata, on the edge that ends the pready=1 cycle; lanes with pstrb[i]=0 SHALL be unchanged.
REQ-024 For an in-range read, SHALL present the memory word on prdata while pready=1, and SHALL hold prdata until the next read completes.
REQ-025 For an out-of-range access, SHALL assert pslverr=1 together with pready=1 using the same wait timing, with no memory write, and prdata unchanged.
REQ-026 SHALL drive pslverr=0 whenever pready=0.
REQ-027 For a write with pstrb all zero, SHALL complete normally with no memory change and pslverr=0.
REQ-028 If psel drops to 0 during ACCESS before pready=1, SHALL abort the transfer, return to IDLE, perform no write, and leave pready=0.
REQ-029 SHALL ignore penable=1 while in IDLE, without starting a transfer.
REQ-030 SHALL accept back-to-back transfers: a setup cycle in the cycle immediately after pready=1 starts the next transfer.

Reset
REQ-031 While rst=1 at a clk edge, SHALL force the state to IDLE, the wait counter to 0, pready=0, pslverr=0, prdata=0, and every memory word to 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no memory write.
- The first setup after rst deasserts SHALL be serviced normally.

Verification
REQ-033 A bench SHALL cover: WAIT_CYCLE=3, write 32'hDEAD_0005 to paddr 5 with pstrb=4'hF -> pready=1 in access cycle 4 only, pslverr=0; a later read of paddr 5 returns 32'hDEAD_0005.
REQ-034 A bench SHALL cover: write 32'hDEAD_0000+i to i=0..31, then read i=0..32 -> each read returns its written value; paddr 32 gives pslverr=1 with prdata held at 32'hDEAD_001F.
REQ-035 A bench SHALL cover: write 32'h1122_3344 to paddr 2, then write 32'hAABB_CCDD with pstrb=4'b0101 -> a read of paddr 2 returns 32'h11BB_33DD.
REQ-036 A bench SHALL cover: WAIT_CYCLE=0 back-to-back writes to paddr 0 and 1 -> pready=1 in every second cycle, and both words are written.
REQ-037 A bench SHALL cover: psel dropped in access cycle 2 of a write to paddr 7 -> no pready, and paddr 7 still reads 0.
REQ-038 A bench SHALL cover: rst=1 asserted during a write wait state -> pready=0 on the next cycle, all memory reads 0, and the next transfer completes normally.
